// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and helpers for the bit-serial ALU sequencer:
//                op-code encoding, sequencer state encoding and op-class
//                decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Op codes as seen by the 1-bit slice, {S2,S1,S0}. The two aliases
    // (001 behaves as SUB, 111 behaves as OR) are listed so that every
    // 3-bit pattern is a legal member of the type.
    typedef enum logic [2:0] {
        PASSB   = 3'b000,
        SUB_ALT = 3'b001,
        ADD     = 3'b010,
        SUB     = 3'b011,
        AND     = 3'b100,
        OR      = 3'b101,
        XOR     = 3'b110,
        OR_ALT  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Arithmetic ops are the ones that produce meaningful carry/overflow.
    function automatic logic is_arith(alu_op_t op);
        return ~op[2] & (op[1] | op[0]);
    endfunction

    // Subtraction is A + ~B + 1, so the carry chain starts at 1.
    function automatic logic carry_preset(alu_op_t op);
        return ~op[2] & op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_ALU.sv
`default_nettype none
// ============================================================================
//  Module      : bit_ALU
//  Description : Existing 1-bit ALU slice. Combinational; select {S2,S1,S0}
//                chooses pass-B, add, subtract (A + ~B + Cin) or a bitwise
//                logic function. Cout is only meaningful for add/subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_ALU (
    input  logic S0,
    input  logic S1,
    input  logic S2,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic out
);

    logic [2:0] w_sel;
    logic       w_b_eff;

    assign w_sel = {S2, S1, S0};

    // Slice function: full adder on (A, B or ~B, Cin) for arithmetic codes,
    // otherwise a plain logic function with the carry output tied low.
    always_comb begin
        w_b_eff = B ^ S0;
        out     = 1'b0;
        Cout    = 1'b0;
        case (w_sel)
            3'b000: out = B;
            3'b001,
            3'b010,
            3'b011: begin
                out  = A ^ w_b_eff ^ Cin;
                Cout = (A & w_b_eff) | (A & Cin) | (w_b_eff & Cin);
            end
            3'b100: out = A & B;
            3'b101,
            3'b111: out = A | B;
            3'b110: out = A ^ B;
            default: out = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_alu_ctrl
//  Description : Sequencer around a single 1-bit ALU slice. Captures two
//                WIDTH-bit operands on start, feeds them LSB-first through
//                the slice while owning the inter-bit carry, assembles the
//                result and derives N/Z/V/C. WIDTH+1 busy cycles per op.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);
    import alu_pkg::*;

    localparam int              CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_SHIFT = SHIFT;
    localparam logic [1:0] c_DONE  = DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    alu_op_t          r_cntrl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_neg;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;

    logic [2:0]       w_sel;
    logic             w_sa;
    logic             w_sb;
    logic             w_scin;
    logic             w_slice_out;
    logic             w_slice_cout;
    logic             w_last;
    logic             w_arith;
    logic [WIDTH-1:0] w_new_result;

    // Next-state decode and slice operand selection.
    always_comb begin
        w_sel        = r_cntrl;
        w_sa         = r_a_sh[0];
        w_sb         = r_b_sh[0];
        w_scin       = r_carry;
        w_last       = (r_cnt == c_LAST);
        w_arith      = is_arith(r_cntrl);
        w_new_result = {w_slice_out, r_res_sh[WIDTH-1:1]};
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_SHIFT;
            c_SHIFT: if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    bit_ALU u_slice (
        .S0   (w_sel[0]),
        .S1   (w_sel[1]),
        .S2   (w_sel[2]),
        .A    (w_sa),
        .B    (w_sb),
        .Cin  (w_scin),
        .Cout (w_slice_cout),
        .out  (w_slice_out)
    );

    // State, operand shifters, carry FF, result and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cntrl  <= PASSB;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_res_sh <= '0;
                        r_cntrl  <= alu_op_t'(cntrl);
                        r_cnt    <= '0;
                        r_carry  <= carry_preset(alu_op_t'(cntrl));
                    end
                end
                c_SHIFT: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= w_new_result;
                    r_carry  <= w_slice_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // r_carry still holds the carry into the MSB here.
                        r_cnt    <= '0;
                        r_result <= w_new_result;
                        r_neg    <= w_new_result[WIDTH-1];
                        r_zero   <= (w_new_result == '0);
                        r_ovf    <= w_arith & (r_carry ^ w_slice_cout);
                        r_cout   <= w_arith & w_slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign result    = r_result;
    assign negative  = r_neg;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign carry_out = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serial_alu_ctrl
//  Description : Self-checking bench for bit_serial_alu_ctrl at WIDTH=8.
//                Directed scenarios plus random ops against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   cntrl = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         carry_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cntrl     (cntrl),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Reference: whole-word arithmetic; flags packed as {N,Z,V,C}.
    task automatic model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] r, output logic [3:0] f);
        logic [W:0] s;
        logic       v;
        logic       c;
        v = 1'b0;
        c = 1'b0;
        r = '0;
        case (op)
            3'b010: begin
                s = {1'b0, av} + {1'b0, bv};
                r = s[W-1:0];
                c = s[W];
                v = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
            end
            3'b001, 3'b011: begin
                s = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
            end
            3'b000: r = bv;
            3'b100: r = av & bv;
            3'b101, 3'b111: r = av | bv;
            default: r = av ^ bv;
        endcase
        f = {r[W-1], (r == '0), v, c};
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, output logic [W-1:0] ro, output logic [3:0] fo);
        int n;
        int busy_n;
        logic [W-1:0] er;
        logic [3:0]   ef;
        @(negedge clk);
        start = 1'b1;
        cntrl = op;
        a     = av;
        b     = bv;
        @(negedge clk);
        start  = 1'b0;
        a      = rnd();
        b      = rnd();
        cntrl  = 3'($urandom);
        n      = 1;
        busy_n = busy ? 1 : 0;
        while (done !== 1'b1 && n < W + 8) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
        ro = result;
        fo = {negative, zero, overflow, carry_out};
        model(op, av, bv, er, ef);
        chk({tag, "_result"}, 64'(ro), 64'(er));
        chk({tag, "_flags"}, 64'(fo), 64'(ef));
        @(negedge clk);
        chk({tag, "_idle_after"}, 64'({busy, done}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [3:0]   f;
        logic [W-1:0] r1;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [3:0]   ef;
        int           n;
        int           dones;
        int           hold_bad;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, result, negative, zero, overflow, carry_out}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 64'({busy, done}), 64'(0));

        // Directed: add with signed overflow
        run_op("add7f01", 3'b010, 8'h7F, 8'h01, r, f);
        chk("add7f01_const", 64'({r, f}), 64'({8'h80, 4'b1010}));
        // Directed: subtract to zero and with borrow
        run_op("sub0505", 3'b011, 8'h05, 8'h05, r, f);
        chk("sub0505_const", 64'({r, f}), 64'({8'h00, 4'b0101}));
        run_op("sub0001", 3'b011, 8'h00, 8'h01, r, f);
        chk("sub0001_const", 64'({r, f}), 64'({8'hFF, 4'b1000}));
        // Directed: logic ops and pass-B
        run_op("and", 3'b100, 8'hCA, 8'h5C, r, f);
        chk("and_const", 64'(r), 64'(8'h48));
        run_op("or", 3'b101, 8'hCA, 8'h5C, r, f);
        chk("or_const", 64'(r), 64'(8'hDE));
        run_op("xor", 3'b110, 8'hCA, 8'h5C, r, f);
        chk("xor_const", 64'(r), 64'(8'h96));
        run_op("passb", 3'b000, 8'hCA, 8'h5C, r, f);
        chk("passb_const", 64'(r), 64'(8'h5C));
        run_op("passb0", 3'b000, 8'hFF, 8'h00, r, f);
        run_op("alias001", 3'b001, 8'h80, 8'h01, r, f);
        run_op("alias111", 3'b111, 8'h0F, 8'h30, r, f);

        // Second start during SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; cntrl = 3'b010; a = 8'h21; b = 8'h13;
        @(negedge clk);
        start = 1'b0;
        model(3'b010, 8'h21, 8'h13, e1, ef);
        dones = 0;
        r1    = '0;
        for (int i = 2; i <= W + 6; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1; cntrl = 3'b110; a = 8'hAA; b = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                r1 = result;
            end
        end
        chk("ignore_start_dones", 64'(dones), 64'(1));
        chk("ignore_start_result", 64'(r1), 64'(e1));

        // Async reset in the middle of SHIFT (bit 3)
        @(negedge clk);
        start = 1'b1; cntrl = 3'b010; a = 8'h55; b = 8'h33;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({busy, done, result, negative, zero, overflow, carry_out}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("reset_no_done", 64'(dones), 64'(0));
        run_op("add1020", 3'b010, 8'h10, 8'h20, r, f);
        chk("add1020_const", 64'(r), 64'(8'h30));

        // Back-to-back with start held high
        model(3'b010, 8'h11, 8'h22, e1, ef);
        model(3'b011, 8'h40, 8'h50, e2, ef);
        @(negedge clk);
        start = 1'b1; cntrl = 3'b010; a = 8'h11; b = 8'h22;
        n = 0;
        while (done !== 1'b1 && n < W + 8) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_result", 64'(result), 64'(e1));
        cntrl = 3'b011; a = 8'h40; b = 8'h50;
        n = 0;
        hold_bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done && result !== e1) hold_bad++;
        end while (done !== 1'b1 && n < 3 * W);
        start = 1'b0;
        chk("b2b_period", 64'(n), 64'(W + 2));
        chk("b2b_hold", 64'(hold_bad), 64'(0));
        chk("b2b_second_result", 64'(result), 64'(e2));
        repeat (2) @(negedge clk);
        chk("b2b_stops", 64'(busy), 64'(0));

        // Random ops across all codes
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), rnd(), rnd(), r, f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
